// File: rtl/clock_set_controller.sv
// ---------------------------------------------------------------------------
// clock_set_controller
//
// Turns the debounced front-panel buttons (set, hours, minutes) into the mode
// code and the one-cycle enable pulse for the desk clock's time register.
//
// In run mode the 1 Hz tick is forwarded to o_en one cycle later. While a set
// button combination is held, the block does the following:
//   - issues a single step after a settle period;
//   - auto-repeats on i_fast_stb once the button has been held for
//     REPEAT_DELAY strobes;
//   - issues a single clear-seconds step when hours and minutes are pressed
//     together.
// o_mode is kept stable, with o_en low, around every mode change.
//
// Ports
//   i_clk       system clock
//   i_reset_n   asynchronous, active-low reset
//   i_sec_stb   1 Hz strobe, one cycle wide
//   i_fast_stb  auto-repeat rate strobe, one cycle wide
//   i_btn_set   set-enable button level
//   i_btn_hr    hours button level
//   i_btn_min   minutes button level
//   o_mode      0=COUNTING 1=SET_MINUTES 2=SET_HOURS 3=CLEAR_SECONDS (registered)
//   o_en        one-cycle enable/step pulse (registered)
// ---------------------------------------------------------------------------
module clock_set_controller #(
  parameter int REPEAT_DELAY  = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_sec_stb,
  input  logic       i_fast_stb,
  input  logic       i_btn_set,
  input  logic       i_btn_hr,
  input  logic       i_btn_min,
  output logic [1:0] o_mode,
  output logic       o_en
);

  localparam int            SW      = $clog2(SETTLE_CYCLES + 1);
  localparam logic [3:0]    REP_MAX = 4'(REPEAT_DELAY);
  localparam logic [SW-1:0] SET_MAX = SW'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SETTLE,
    ST_STEP,
    ST_HOLD,
    ST_REPEAT,
    ST_EXIT
  } state_t;

  state_t        state;
  logic [1:0]    target;
  logic [SW-1:0] settle_cnt;
  logic [3:0]    rep_cnt;

  logic [1:0]    req_target;
  logic          entry_req;
  logic          sel_btn;
  logic          hold_release;
  logic [3:0]    rep_next;
  logic [SW-1:0] settle_next;

  function automatic logic [3:0] rep_sat_inc(input logic [3:0] v);
    return (v >= REP_MAX) ? REP_MAX : v + 4'd1;
  endfunction

  function automatic logic [SW-1:0] settle_sat_inc(input logic [SW-1:0] v);
    return (v >= SET_MAX) ? SET_MAX : v + SW'(1);
  endfunction

  // {hr, min} maps directly onto the mode code: 01=minutes, 10=hours, 11=clear.
  assign req_target   = {i_btn_hr, i_btn_min};
  assign entry_req    = i_btn_set && (i_btn_hr || i_btn_min);
  // Only the button that selected the target keeps the operation alive;
  // the other one is ignored until the operation ends.
  assign sel_btn      = (target == 2'd2) ? i_btn_hr : i_btn_min;
  assign hold_release = !i_btn_set || !sel_btn;
  assign rep_next     = rep_sat_inc(rep_cnt);
  assign settle_next  = settle_sat_inc(settle_cnt);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ST_RUN;
      target     <= 2'd0;
      settle_cnt <= '0;
      rep_cnt    <= '0;
      o_mode     <= 2'd0;
      o_en       <= 1'b0;
    end else begin
      o_en <= 1'b0;
      case (state)
        ST_RUN: begin
          o_mode <= 2'd0;
          if (entry_req) begin
            // The 1 Hz strobe coinciding with entry is dropped.
            target     <= req_target;
            o_mode     <= req_target;
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end else begin
            o_en <= i_sec_stb;
          end
        end

        ST_SETTLE: begin
          settle_cnt <= settle_next;
          if (settle_next == SET_MAX) begin
            o_en  <= 1'b1;
            state <= ST_STEP;
          end
        end

        ST_STEP: begin
          rep_cnt <= '0;
          if (target == 2'd3) begin
            // o_en is high this cycle, so o_mode is held one more cycle;
            // EXIT clears it afterwards.
            settle_cnt <= '0;
            state      <= ST_EXIT;
          end else begin
            state <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (hold_release) begin
            o_mode     <= 2'd0;
            settle_cnt <= '0;
            state      <= ST_EXIT;
          end else if (i_fast_stb) begin
            rep_cnt <= rep_next;
            if (rep_next == REP_MAX) begin
              o_en  <= 1'b1;
              state <= ST_REPEAT;
            end
          end
        end

        ST_REPEAT: begin
          if (hold_release) begin
            // Keep o_mode for the cycle after a pulse.
            if (!o_en) o_mode <= 2'd0;
            settle_cnt <= '0;
            state      <= ST_EXIT;
          end else if (i_fast_stb && !o_en) begin
            o_en <= 1'b1;
          end
        end

        ST_EXIT: begin
          o_mode <= 2'd0;
          // Settle time is counted only once o_mode has actually returned to 0.
          if (o_mode == 2'd0) begin
            settle_cnt <= settle_next;
            if (settle_next == SET_MAX && !i_btn_hr && !i_btn_min) begin
              state <= ST_RUN;
            end
          end
        end

        default: begin
          o_mode <= 2'd0;
          state  <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_set_controller.sv
module tb_clock_set_controller;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       sec_stb  = 1'b0;
  logic       fast_stb = 1'b0;
  logic       btn_set  = 1'b0;
  logic       btn_hr   = 1'b0;
  logic       btn_min  = 1'b0;
  logic [1:0] o_mode;
  logic       o_en;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clock_set_controller #(
    .REPEAT_DELAY (8),
    .SETTLE_CYCLES(2)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_sec_stb (sec_stb),
    .i_fast_stb(fast_stb),
    .i_btn_set (btn_set),
    .i_btn_hr  (btn_hr),
    .i_btn_min (btn_min),
    .o_mode    (o_mode),
    .o_en      (o_en)
  );

  // Inputs set before step() are sampled at the edge; outputs read after
  // step() show the response one cycle later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    sec_stb = 1'b1;
    step();
    checks++;
    if (o_mode !== 2'd0) begin
      failures++;
      $display("FAIL reset_mode got=%0d exp=0", o_mode);
    end
    checks++;
    if (o_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_en got=%b exp=0", o_en);
    end
    sec_stb = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_run_tick();
    int   pulses = 0;
    logic exp_en;
    for (int k = 0; k < 150; k++) begin
      exp_en  = (k % 50 == 10);
      sec_stb = exp_en;
      step();
      if (o_en === 1'b1) pulses++;
      checks++;
      if (o_en !== exp_en || o_mode !== 2'd0) begin
        failures++;
        $display("FAIL run_tick k=%0d en=%b mode=%0d exp_en=%b exp_mode=0", k, o_en, o_mode, exp_en);
      end
    end
    sec_stb = 1'b0;
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL run_tick_count got=%0d exp=3", pulses);
    end
  endtask

  task automatic test_set_min_short();
    logic exp_en;
    btn_set = 1'b1;
    btn_min = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      exp_en = (c == 2);
      checks++;
      if (o_en !== exp_en || o_mode !== 2'd1) begin
        failures++;
        $display("FAIL min_entry c=%0d en=%b mode=%0d exp_en=%b exp_mode=1", c, o_en, o_mode, exp_en);
      end
    end
    // Seven strobes: one short of the repeat threshold.
    for (int s = 1; s <= 7; s++) begin
      fast_stb = 1'b1;
      for (int j = 0; j < 4; j++) begin
        step();
        fast_stb = 1'b0;
        checks++;
        if (o_en !== 1'b0 || o_mode !== 2'd1) begin
          failures++;
          $display("FAIL min_hold s=%0d j=%0d en=%b mode=%0d exp_en=0 exp_mode=1", s, j, o_en, o_mode);
        end
      end
    end
    btn_set = 1'b0;
    btn_min = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (o_en !== 1'b0 || o_mode !== 2'd0) begin
        failures++;
        $display("FAIL min_exit c=%0d en=%b mode=%0d exp_en=0 exp_mode=0", c, o_en, o_mode);
      end
    end
  endtask

  task automatic test_set_hr_repeat();
    int   pulses = 0;
    logic exp_en;
    btn_set = 1'b1;
    btn_hr  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      exp_en = (c == 2);
      if (o_en === 1'b1) pulses++;
      checks++;
      if (o_en !== exp_en || o_mode !== 2'd2) begin
        failures++;
        $display("FAIL hr_entry c=%0d en=%b mode=%0d exp_en=%b exp_mode=2", c, o_en, o_mode, exp_en);
      end
    end
    for (int s = 1; s <= 20; s++) begin
      fast_stb = 1'b1;
      step();
      fast_stb = 1'b0;
      exp_en   = (s >= 8);
      if (o_en === 1'b1) pulses++;
      checks++;
      if (o_en !== exp_en || o_mode !== 2'd2) begin
        failures++;
        $display("FAIL hr_repeat s=%0d en=%b mode=%0d exp_en=%b exp_mode=2", s, o_en, o_mode, exp_en);
      end
      for (int j = 0; j < 3; j++) begin
        step();
        if (o_en === 1'b1) pulses++;
        checks++;
        if (o_en !== 1'b0 || o_mode !== 2'd2) begin
          failures++;
          $display("FAIL hr_gap s=%0d j=%0d en=%b mode=%0d exp_en=0 exp_mode=2", s, j, o_en, o_mode);
        end
      end
    end
    checks++;
    if (pulses != 14) begin
      failures++;
      $display("FAIL hr_pulse_count got=%0d exp=14", pulses);
    end
    // Release hours with set still held: no re-trigger.
    btn_hr = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (o_en !== 1'b0 || o_mode !== 2'd0) begin
        failures++;
        $display("FAIL hr_exit c=%0d en=%b mode=%0d exp_en=0 exp_mode=0", c, o_en, o_mode);
      end
    end
    btn_set = 1'b0;
    step();
  endtask

  task automatic test_clear_seconds();
    logic       exp_en;
    logic [1:0] exp_mode;
    btn_set = 1'b1;
    btn_hr  = 1'b1;
    btn_min = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      exp_en   = (c == 2);
      exp_mode = (c < 4) ? 2'd3 : 2'd0;
      checks++;
      if (o_en !== exp_en || o_mode !== exp_mode) begin
        failures++;
        $display("FAIL clr_entry c=%0d en=%b mode=%0d exp_en=%b exp_mode=%0d", c, o_en, o_mode, exp_en, exp_mode);
      end
    end
    // Held buttons keep EXIT waiting; fast and 1 Hz strobes produce nothing.
    for (int c = 0; c < 40; c++) begin
      fast_stb = (c % 4 == 0);
      sec_stb  = (c == 21);
      step();
      checks++;
      if (o_en !== 1'b0 || o_mode !== 2'd0) begin
        failures++;
        $display("FAIL clr_hold c=%0d en=%b mode=%0d exp_en=0 exp_mode=0", c, o_en, o_mode);
      end
    end
    fast_stb = 1'b0;
    sec_stb  = 1'b0;
    btn_hr   = 1'b0;
    btn_min  = 1'b0;
    step();
    checks++;
    if (o_en !== 1'b0 || o_mode !== 2'd0) begin
      failures++;
      $display("FAIL clr_release en=%b mode=%0d exp_en=0 exp_mode=0", o_en, o_mode);
    end
    sec_stb = 1'b1;
    step();
    sec_stb = 1'b0;
    checks++;
    if (o_en !== 1'b1 || o_mode !== 2'd0) begin
      failures++;
      $display("FAIL clr_back_to_run en=%b mode=%0d exp_en=1 exp_mode=0", o_en, o_mode);
    end
    btn_set = 1'b0;
    step();
  endtask

  task automatic test_dropped_strobes();
    // Each row: inputs for one cycle and the expected outputs after it.
    logic [1:0] sets [12];
    logic       secs [12];
    logic       ens  [12];
    logic [1:0] modes[12];
    // sets: bit1 = set button, bit0 = min button
    sets  = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    secs  = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};
    ens   = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
    modes = '{2'd1,  2'd1,  2'd1,  2'd1,  2'd1,  2'd1,  2'd0,  2'd0,  2'd0,  2'd0,  2'd0,  2'd0};
    for (int r = 0; r < 12; r++) begin
      btn_set = sets[r][1];
      btn_min = sets[r][0];
      sec_stb = secs[r];
      step();
      checks++;
      if (o_en !== ens[r] || o_mode !== modes[r]) begin
        failures++;
        $display("FAIL drop r=%0d en=%b mode=%0d exp_en=%b exp_mode=%0d", r, o_en, o_mode, ens[r], modes[r]);
      end
    end
    sec_stb = 1'b0;
  endtask

  task automatic test_async_reset();
    logic exp_en;
    btn_set = 1'b1;
    btn_min = 1'b1;
    step();
    step();
    step();
    step();
    for (int s = 1; s <= 8; s++) begin
      fast_stb = 1'b1;
      step();
      fast_stb = 1'b0;
      step();
      step();
      step();
    end
    fast_stb = 1'b1;
    step();
    fast_stb = 1'b0;
    checks++;
    if (o_en !== 1'b1 || o_mode !== 2'd1) begin
      failures++;
      $display("FAIL areset_pre en=%b mode=%0d exp_en=1 exp_mode=1", o_en, o_mode);
    end
    // Assert reset mid-cycle, well away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_en !== 1'b0 || o_mode !== 2'd0) begin
      failures++;
      $display("FAIL areset_immediate en=%b mode=%0d exp_en=0 exp_mode=0", o_en, o_mode);
    end
    step();
    checks++;
    if (o_en !== 1'b0 || o_mode !== 2'd0) begin
      failures++;
      $display("FAIL areset_held en=%b mode=%0d exp_en=0 exp_mode=0", o_en, o_mode);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      exp_en = (c == 2);
      checks++;
      if (o_en !== exp_en || o_mode !== 2'd1) begin
        failures++;
        $display("FAIL areset_reentry c=%0d en=%b mode=%0d exp_en=%b exp_mode=1", c, o_en, o_mode, exp_en);
      end
    end
    btn_set = 1'b0;
    btn_min = 1'b0;
    for (int c = 0; c < 4; c++) step();
    checks++;
    if (o_en !== 1'b0 || o_mode !== 2'd0) begin
      failures++;
      $display("FAIL areset_final en=%b mode=%0d exp_en=0 exp_mode=0", o_en, o_mode);
    end
  endtask

  initial begin
    test_reset();
    test_run_tick();
    test_set_min_short();
    test_set_hr_repeat();
    test_clear_seconds();
    test_dropped_strobes();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
